// File: rtl/l2_instr_mem_responder.sv
// Stub L2 instruction memory on the common instruction bus: serves line-fill reads
// after a fixed latency and drives the shared data bus until the granted cache lets go.
module l2_instr_mem_responder #(
    parameter int ADDR_W         = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 3,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Com_Bus_Gnt_any,
    input  logic [ADDR_W-1:0]         Address_Com,
    inout  wire  [ADDR_W-1:0]         Data_Bus_Com,
    inout  wire                       Data_in_Bus,
    input  logic                      Mem_wr_en,
    input  logic [MEM_DEPTH_LOG2-1:0] Mem_wr_addr,
    input  logic [ADDR_W-1:0]         Mem_wr_data,
    output logic                      Busy,
    output logic [CNT_W-1:0]          Resp_count
);

    // state | meaning
    // IDLE  | buses released, waiting for a granted cycle with a valid address
    // WAIT  | word index captured, counting down the read latency
    // RESP  | driving Data_Bus_Com / Data_in_Bus until the grant drops
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         MEM_WORDS = 1 << MEM_DEPTH_LOG2;
    localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY - 1);

    logic [1:0]                state;
    logic                      gnt_d1;
    logic [3:0]                lat_cnt;
    logic [MEM_DEPTH_LOG2-1:0] rd_idx;
    logic [ADDR_W-1:0]         resp_data;
    logic [ADDR_W-1:0]         mem [MEM_WORDS];
    logic                      addr_valid;
    logic                      drive;
    logic                      unused_addr_bits;

    // The granted cache only drives Address_Com from the edge after it sees grant.
    assign addr_valid = Com_Bus_Gnt_any & gnt_d1;
    assign unused_addr_bits = ^{Address_Com[ADDR_W-1:MEM_DEPTH_LOG2+2], Address_Com[1:0]};

    always_ff @(posedge clk) begin
        if (Mem_wr_en) begin
            mem[Mem_wr_addr] <= Mem_wr_data;
        end
    end

    // Every request goes through WAIT, so the first response edge is exactly
    // READ_LATENCY edges after capture, including READ_LATENCY=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gnt_d1     <= 1'b0;
            lat_cnt    <= '0;
            rd_idx     <= '0;
            resp_data  <= '0;
            Resp_count <= '0;
        end else begin
            gnt_d1 <= Com_Bus_Gnt_any;
            case (state)
                S_IDLE: begin
                    if (addr_valid) begin
                        rd_idx  <= Address_Com[MEM_DEPTH_LOG2+1:2];
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!Com_Bus_Gnt_any) begin
                        state <= S_IDLE;
                    end else if (lat_cnt == 4'd0) begin
                        resp_data <= mem[rd_idx];
                        state     <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (!Com_Bus_Gnt_any) begin
                        state <= S_IDLE;
                        if (Resp_count != {CNT_W{1'b1}}) begin
                            Resp_count <= Resp_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign drive        = (state == S_RESP);
    assign Busy         = (state != S_IDLE);
    assign Data_Bus_Com = drive ? resp_data : {ADDR_W{1'bz}};
    assign Data_in_Bus  = drive ? 1'b1 : 1'bz;

endmodule
